// File: rtl/ir_lcd_pkg.sv
// Shared constants and state encoding for the IR-to-LCD entry controller.
// Key codes, LCD instruction bytes and FSM states.
package ir_lcd_pkg;

  localparam logic [7:0] KEY_CLEAR_DEF = 8'h0F;
  localparam logic [7:0] KEY_BACK_DEF  = 8'h0E;
  localparam logic [7:0] KEY_ENTER_DEF = 8'h12;
  localparam logic [7:0] KEY_DIGIT_MAX = 8'h09;

  localparam logic [7:0] LCD_CLEAR  = 8'h01;
  localparam logic [7:0] DDRAM_ROW0 = 8'h80;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_SP   = 8'h20;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DECODE,
    S_SET_ADDR,
    S_WR_CHAR,
    S_CLR,
    S_DONE
  } state_t;

endpackage

// File: rtl/lcd_wr_port.sv
// Single-byte LCD write port: holds req/cmd/byte from start until ack.
// done is the ack cycle itself, so req is low the following cycle.
module lcd_wr_port (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       start_cmd,
  input  logic [7:0] start_byte,
  input  logic       ack,
  output logic       req,
  output logic       cmd,
  output logic [7:0] data,
  output logic       done
);

  assign done = req & ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req  <= 1'b0;
      cmd  <= 1'b0;
      data <= 8'h00;
    end else if (done) begin
      req <= 1'b0;
    end else if (start && !req) begin
      req  <= 1'b1;
      cmd  <= start_cmd;
      data <= start_byte;
    end
  end

endmodule

// File: rtl/ir_lcd_entry_ctrl.sv
// IR key to LCD entry-field sequencer with a one-deep pending key slot.
// Tracks digit count, binary value and sticky saturation of the entry.
module ir_lcd_entry_ctrl
  import ir_lcd_pkg::*;
#(
  parameter int         LINE_LEN  = 16,
  parameter int         VALUE_W   = 16,
  parameter logic [7:0] KEY_CLEAR = KEY_CLEAR_DEF,
  parameter logic [7:0] KEY_BACK  = KEY_BACK_DEF,
  parameter logic [7:0] KEY_ENTER = KEY_ENTER_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  output logic               lcd_wr_req,
  output logic               lcd_cmd,
  output logic [7:0]         lcd_byte,
  input  logic               lcd_wr_ack,
  output logic [4:0]         entry_len,
  output logic [VALUE_W-1:0] entry_value,
  output logic               entry_sat,
  output logic               entry_done,
  output logic               key_dropped
);

  localparam logic [4:0] LEN_MAX = 5'(LINE_LEN);
  localparam int         MW      = VALUE_W + 4;

  state_t state, state_nx;

  logic [7:0]    key;
  logic [7:0]    pend;
  logic          pend_vld;
  logic          issued;
  logic          start;
  logic          start_cmd;
  logic [7:0]    start_byte;
  logic          done;
  logic          is_digit;
  logic          is_back;
  logic          is_clear;
  logic          is_enter;
  logic [3:0]    digit;
  logic [4:0]    addr;
  logic [MW-1:0] mul;
  logic          ovf;

  assign is_digit = (key <= KEY_DIGIT_MAX);
  assign is_back  = (key == KEY_BACK);
  assign is_clear = (key == KEY_CLEAR);
  assign is_enter = (key == KEY_ENTER);
  assign digit    = key[3:0];
  assign addr     = is_digit ? entry_len : entry_len - 5'd1;
  assign mul      = MW'(entry_value) * MW'(10) + MW'(digit);
  assign ovf      = |mul[MW-1:VALUE_W];

  assign key_dropped = key_valid && (state != S_IDLE) && pend_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:     if (done) state_nx = S_IDLE;
      S_IDLE:     if (pend_vld || key_valid) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_digit: state_nx = (entry_len < LEN_MAX) ? S_SET_ADDR : S_IDLE;
          is_back:  state_nx = (entry_len != 5'd0) ? S_SET_ADDR : S_IDLE;
          is_clear: state_nx = S_CLR;
          is_enter: state_nx = S_DONE;
          default:  state_nx = S_IDLE;
        endcase
      end
      S_SET_ADDR: if (done) state_nx = S_WR_CHAR;
      S_WR_CHAR:  if (done) state_nx = S_IDLE;
      S_CLR:      if (done) state_nx = S_IDLE;
      S_DONE:     state_nx = S_CLR;
      default:    state_nx = S_INIT;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    start_cmd  = 1'b0;
    start_byte = 8'h00;
    entry_done = 1'b0;
    unique case (state)
      S_INIT, S_CLR: begin
        start      = !issued;
        start_cmd  = 1'b1;
        start_byte = LCD_CLEAR;
      end
      S_SET_ADDR: begin
        start      = !issued;
        start_cmd  = 1'b1;
        start_byte = DDRAM_ROW0 | {3'b000, addr};
      end
      S_WR_CHAR: begin
        start      = !issued;
        start_byte = is_digit ? ASCII_0 + {4'h0, digit} : ASCII_SP;
      end
      S_DONE:  entry_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key         <= 8'h00;
      pend        <= 8'h00;
      pend_vld    <= 1'b0;
      issued      <= 1'b0;
      entry_len   <= 5'd0;
      entry_value <= '0;
      entry_sat   <= 1'b0;
    end else begin
      if (start) issued <= 1'b1;
      if (done)  issued <= 1'b0;
      // The slot drains only in IDLE; a key arriving that cycle refills it.
      if (state == S_IDLE) begin
        if (pend_vld) begin
          key      <= pend;
          pend_vld <= key_valid;
          if (key_valid) pend <= key_code;
        end else if (key_valid) begin
          key <= key_code;
        end
      end else if (key_valid && !pend_vld) begin
        pend     <= key_code;
        pend_vld <= 1'b1;
      end
      if (state == S_WR_CHAR && done) begin
        if (is_digit) begin
          entry_len   <= entry_len + 5'd1;
          entry_value <= ovf ? '1 : mul[VALUE_W-1:0];
          if (ovf) entry_sat <= 1'b1;
        end else begin
          entry_len <= entry_len - 5'd1;
          if (!entry_sat) entry_value <= entry_value / VALUE_W'(10);
        end
      end
      if (state == S_CLR && done) begin
        entry_len   <= 5'd0;
        entry_value <= '0;
        entry_sat   <= 1'b0;
      end
    end
  end

  lcd_wr_port u_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_cmd  (start_cmd),
    .start_byte (start_byte),
    .ack        (lcd_wr_ack),
    .req        (lcd_wr_req),
    .cmd        (lcd_cmd),
    .data       (lcd_byte),
    .done       (done)
  );

endmodule
